// File: rtl/ripple_timer_ctrl.sv
// ripple_timer_ctrl: filtered, extended timer fed by an asynchronous 4-bit ripple counter
//   clk       : system clock, rising edge
//   clr       : asynchronous active-low reset
//   cnt_in    : ripple counter value, asynchronous to clk
//   start     : arm/re-arm pulse, samples match_val and periodic
//   stop      : disarm pulse, wins over start
//   periodic  : 1 = periodic, 0 = one-shot
//   match_val : elapsed-count threshold (0 makes start a no-op)
//   irq_ack   : clears irq and overrun
//   irq       : level interrupt
//   overrun   : sticky, a hit arrived while irq was still pending
//   busy      : armed
//   count     : filtered, extended running count
module ripple_timer_ctrl #(
   parameter int EXT_W = 12,
   localparam int W = EXT_W + 4
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [3:0]   cnt_in,
   input  logic         start,
   input  logic         stop,
   input  logic         periodic,
   input  logic [W-1:0] match_val,
   input  logic         irq_ack,
   output logic         irq,
   output logic         overrun,
   output logic         busy,
   output logic [W-1:0] count
);
   typedef enum logic {IDLE, ARMED} state_t;
   state_t       r_state, w_next;
   logic [3:0]   r_s1, r_s2, r_s3, r_last;
   logic [1:0]   r_fill;
   logic         r_primed, r_per, r_irq, r_overrun;
   logic [W-1:0] r_count, r_base, r_match;
   logic         w_accept, w_start_tk, w_hit;
   logic [3:0]   w_delta;
   logic [W-1:0] w_elapsed;
   // r_fill holds off acceptance until s3 carries a real post-reset sample
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_s1   <= '0;
         r_s2   <= '0;
         r_s3   <= '0;
         r_fill <= '0;
      end else begin
         r_s1   <= cnt_in;
         r_s2   <= r_s1;
         r_s3   <= r_s2;
         r_fill <= r_fill + {1'b0, r_fill != 2'd3};
      end
   end
   // a value seen on two consecutive cycles cannot be a ripple transient
   assign w_accept = (r_fill == 2'd3) && (r_s2 == r_s3);
   assign w_delta  = r_s2 - r_last;
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_last   <= '0;
         r_primed <= 1'b0;
         r_count  <= '0;
      end else if (w_accept) begin
         r_last   <= r_s2;
         r_primed <= 1'b1;
         r_count  <= r_primed ? r_count + W'(w_delta) : r_count;
      end
   end
   assign w_elapsed  = r_count - r_base;
   assign w_start_tk = start && (match_val != '0);
   assign w_hit      = (r_state == ARMED) && (w_elapsed >= r_match) && !stop && !w_start_tk;
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) r_state <= IDLE;
      else      r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      if (stop)                 w_next = IDLE;
      else if (w_start_tk)      w_next = ARMED;
      else if (w_hit && !r_per) w_next = IDLE;
   end
   // periodic mode advances base by exactly match_r so no elapsed counts are dropped
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_base  <= '0;
         r_match <= '0;
         r_per   <= 1'b0;
      end else if (!stop && w_start_tk) begin
         r_base  <= r_count;
         r_match <= match_val;
         r_per   <= periodic;
      end else if (w_hit && r_per) begin
         r_base  <= r_base + r_match;
      end
   end
   // an ack coinciding with a hit consumes the previous event only
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_irq     <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_hit) begin
         r_irq     <= 1'b1;
         r_overrun <= !irq_ack && (r_irq || r_overrun);
      end else if (irq_ack) begin
         r_irq     <= 1'b0;
         r_overrun <= 1'b0;
      end
   end
   assign irq     = r_irq;
   assign overrun = r_overrun;
   assign busy    = (r_state == ARMED);
   assign count   = r_count;
endmodule

// File: tb/tb_ripple_timer_ctrl.sv
// tb_ripple_timer_ctrl: directed vectors and corner sequences for ripple_timer_ctrl
module tb_ripple_timer_ctrl;
   typedef struct {
      logic [3:0]  cnt;
      logic        st, sp, per;
      logic [15:0] mv;
      logic        ack, e_irq, e_ovr, e_busy;
      logic [15:0] e_cnt;
   } vec_t;
   logic        clk = 1'b0;
   logic        clr, start, stop, periodic, irq_ack;
   logic [3:0]  cnt_in;
   logic [15:0] match_val;
   logic        irq, overrun, busy;
   logic [15:0] count;
   int          checks = 0;
   int          failures = 0;
   vec_t        tbl[$];
   logic [3:0]  c;
   ripple_timer_ctrl #(.EXT_W(12)) dut (
      .clk(clk), .clr(clr), .cnt_in(cnt_in), .start(start), .stop(stop),
      .periodic(periodic), .match_val(match_val), .irq_ack(irq_ack),
      .irq(irq), .overrun(overrun), .busy(busy), .count(count)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(input int cn, input int s, input int p, input int pe, input int m,
                               input int a, input int ei, input int eo, input int eb, input int ec);
      vec_t v;
      v.cnt = 4'(cn); v.st = 1'(s); v.sp = 1'(p); v.per = 1'(pe); v.mv = 16'(m);
      v.ack = 1'(a); v.e_irq = 1'(ei); v.e_ovr = 1'(eo); v.e_busy = 1'(eb); v.e_cnt = 16'(ec);
      return v;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic chk_all(input string tag, input logic ei, input logic eo, input logic eb, input logic [15:0] ec);
      chk({tag, "_irq"}, 32'(irq), 32'(ei));
      chk({tag, "_ovr"}, 32'(overrun), 32'(eo));
      chk({tag, "_busy"}, 32'(busy), 32'(eb));
      chk({tag, "_count"}, 32'(count), 32'(ec));
   endtask
   initial begin
      clr = 1'b0; cnt_in = 4'd0; start = 1'b0; stop = 1'b0;
      periodic = 1'b0; match_val = '0; irq_ack = 1'b0;
      #2;
      chk_all("reset", 1'b0, 1'b0, 1'b0, 16'd0);
      @(posedge clk);
      #1 clr = 1'b1;
      step(6);
      chk("prime0_count", 32'(count), 32'd0);
      cnt_in = 4'd1;
      step(3);
      chk("lat_before", 32'(count), 32'd0);
      step(1);
      chk("lat_exact", 32'(count), 32'd1);
      cnt_in = 4'd7;
      step(4);
      chk("to7", 32'(count), 32'd7);
      cnt_in = 4'd0;
      step(1);
      chk("glitch0", 32'(count), 32'd7);
      cnt_in = 4'd8;
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk($sformatf("glitch_hold%0d", i), 32'(count), 32'd7);
      end
      step(1);
      chk("glitch_to8", 32'(count), 32'd8);
      // one-shot, base 8, match 5
      tbl.push_back(mk( 8,1,0,0,5,0, 0,0,1, 8));
      tbl.push_back(mk( 9,0,0,0,0,0, 0,0,1, 8));
      tbl.push_back(mk( 9,0,0,0,0,0, 0,0,1, 8));
      tbl.push_back(mk(10,0,0,0,0,0, 0,0,1, 8));
      tbl.push_back(mk(10,0,0,0,0,0, 0,0,1, 9));
      tbl.push_back(mk(11,0,0,0,0,0, 0,0,1, 9));
      tbl.push_back(mk(11,0,0,0,0,0, 0,0,1,10));
      tbl.push_back(mk(12,0,0,0,0,0, 0,0,1,10));
      tbl.push_back(mk(12,0,0,0,0,0, 0,0,1,11));
      tbl.push_back(mk(13,0,0,0,0,0, 0,0,1,11));
      tbl.push_back(mk(13,0,0,0,0,0, 0,0,1,12));
      tbl.push_back(mk(13,0,0,0,0,0, 0,0,1,12));
      tbl.push_back(mk(13,0,0,0,0,0, 0,0,1,13));
      tbl.push_back(mk(13,0,0,0,0,0, 1,0,0,13));
      tbl.push_back(mk(13,0,0,0,0,1, 0,0,0,13));
      // periodic, base 13, match 3: hits at 16, 19 (overrun), 22 (with ack)
      tbl.push_back(mk(13,1,0,1,3,0, 0,0,1,13));
      tbl.push_back(mk(14,0,0,0,0,0, 0,0,1,13));
      tbl.push_back(mk(14,0,0,0,0,0, 0,0,1,13));
      tbl.push_back(mk(15,0,0,0,0,0, 0,0,1,13));
      tbl.push_back(mk(15,0,0,0,0,0, 0,0,1,14));
      tbl.push_back(mk( 0,0,0,0,0,0, 0,0,1,14));
      tbl.push_back(mk( 0,0,0,0,0,0, 0,0,1,15));
      tbl.push_back(mk( 1,0,0,0,0,0, 0,0,1,15));
      tbl.push_back(mk( 1,0,0,0,0,0, 0,0,1,16));
      tbl.push_back(mk( 2,0,0,0,0,0, 1,0,1,16));
      tbl.push_back(mk( 2,0,0,0,0,0, 1,0,1,17));
      tbl.push_back(mk( 3,0,0,0,0,0, 1,0,1,17));
      tbl.push_back(mk( 3,0,0,0,0,0, 1,0,1,18));
      tbl.push_back(mk( 4,0,0,0,0,0, 1,0,1,18));
      tbl.push_back(mk( 4,0,0,0,0,0, 1,0,1,19));
      tbl.push_back(mk( 5,0,0,0,0,0, 1,1,1,19));
      tbl.push_back(mk( 5,0,0,0,0,0, 1,1,1,20));
      tbl.push_back(mk( 6,0,0,0,0,0, 1,1,1,20));
      tbl.push_back(mk( 6,0,0,0,0,0, 1,1,1,21));
      tbl.push_back(mk( 6,0,0,0,0,0, 1,1,1,21));
      tbl.push_back(mk( 6,0,0,0,0,0, 1,1,1,22));
      tbl.push_back(mk( 6,0,0,0,0,1, 1,0,1,22));
      tbl.push_back(mk( 6,0,0,0,0,0, 1,0,1,22));
      foreach (tbl[i]) begin
         cnt_in = tbl[i].cnt; start = tbl[i].st; stop = tbl[i].sp;
         periodic = tbl[i].per; match_val = tbl[i].mv; irq_ack = tbl[i].ack;
         step(1);
         chk_all($sformatf("row%0d", i), tbl[i].e_irq, tbl[i].e_ovr, tbl[i].e_busy, tbl[i].e_cnt);
      end
      start = 1'b0; stop = 1'b0; periodic = 1'b0; match_val = '0; irq_ack = 1'b0;
      // asynchronous reset while armed with irq pending
      #2 clr = 1'b0;
      #1;
      chk_all("async_rst", 1'b0, 1'b0, 1'b0, 16'd0);
      cnt_in = 4'd14;
      step(2);
      clr = 1'b1;
      step(6);
      chk("prime14_count", 32'(count), 32'd0);
      cnt_in = 4'd15;
      step(4);
      chk("wrap15", 32'(count), 32'd1);
      cnt_in = 4'd0;
      step(4);
      chk("wrap0", 32'(count), 32'd2);
      cnt_in = 4'd1;
      step(4);
      chk("wrap1", 32'(count), 32'd3);
      // drive count to 0xFFFF with +15 steps, then one more increment
      c = 4'd1;
      for (int i = 0; i < 4368; i++) begin
         c = c + 4'd15;
         cnt_in = c;
         step(2);
      end
      c = c + 4'd12;
      cnt_in = c;
      step(6);
      chk("count_ffff", 32'(count), 32'hFFFF);
      c = c + 4'd1;
      cnt_in = c;
      step(4);
      chk("count_wrap0", 32'(count), 32'h0);
      // corner pulses
      start = 1'b1; match_val = 16'd100;
      step(1);
      chk("arm_busy", 32'(busy), 32'd1);
      match_val = 16'd0;
      step(1);
      chk("arm_mv0_ignored", 32'(busy), 32'd1);
      stop = 1'b1; match_val = 16'd100;
      step(1);
      chk("start_stop_armed", 32'(busy), 32'd0);
      step(1);
      chk("start_stop_idle", 32'(busy), 32'd0);
      stop = 1'b0; match_val = 16'd0;
      step(1);
      start = 1'b0;
      chk("mv0_busy", 32'(busy), 32'd0);
      step(3);
      chk("mv0_busy_late", 32'(busy), 32'd0);
      chk("mv0_irq", 32'(irq), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
